// File: rtl/config_chain_driver_pkg.sv
// Shared definitions for the configuration daisy chain: driver FSM encoding
// and the per-block configuration length used by the chained blocks.
package config_chain_driver_pkg;

  localparam int CFG_BITS_PER_BLOCK = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHIFT,
    ST_WAIT_TOK,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-bit serializer: MSB-first shift register with a valid/ready word
// load that can refill in place during the final bit of the current word.
module cfg_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_ld_en,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_bit_vld,
  output logic              o_bit
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_has;
  logic              w_last;
  logic              w_load;

  assign w_has        = (r_cnt != '0);
  assign w_last       = (r_cnt == CNT_W'(1));
  assign o_bit_vld    = i_en && w_has;
  assign o_bit        = o_bit_vld && r_sr[WORD_W-1];
  // Ready when empty, or when the bit leaving now is the last one held.
  assign o_word_ready = i_ld_en && (!w_has || (w_last && i_en));
  assign w_load       = o_word_ready && i_word_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sr  <= i_word_data;
      r_cnt <= CNT_W'(WORD_W);
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (o_bit_vld) begin
      r_sr  <= r_sr << 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/config_chain_driver.sv
// Drives a programming pass through a daisy chain of configuration blocks:
// streams NUM_BLOCKS*BITS_PER_BLOCK bits, then waits for the returned token.
module config_chain_driver
  import config_chain_driver_pkg::*;
#(
  parameter int BITS_PER_BLOCK = CFG_BITS_PER_BLOCK,
  parameter int NUM_BLOCKS     = 4,
  parameter int WORD_W         = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_prgm_b,
  output logic              o_cb_prgm_b,
  output logic              o_cfg_data,
  input  logic              i_chain_done_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int TOTAL_BITS = NUM_BLOCKS * BITS_PER_BLOCK;
  localparam int BCNT_W     = $clog2(TOTAL_BITS + 1);
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(TOTAL_BITS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  cfg_state_t        r_state, w_state_nxt;
  logic [BCNT_W-1:0] r_bitcnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_done, r_error;
  logic              w_bit_vld, w_bit, w_last_bit, w_ld_en, w_shift_en, w_ser_clr;
  logic              w_busy;

  assign w_shift_en = (r_state == ST_SHIFT);
  assign w_ser_clr  = (r_state != ST_SHIFT);
  assign w_last_bit = w_bit_vld && (r_bitcnt == LAST_BIT);
  // Preload during ARM so the first bit goes out on the first SHIFT cycle;
  // no refill once the final pass bit is leaving or an early token shows up.
  assign w_ld_en    = (r_state == ST_ARM) ||
                      (w_shift_en && !i_chain_done_in && !w_last_bit);

  cfg_serializer #(.WORD_W(WORD_W)) u_ser (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clr        (w_ser_clr),
    .i_en         (w_shift_en),
    .i_ld_en      (w_ld_en),
    .i_word_data  (i_word_data),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_bit_vld    (w_bit_vld),
    .o_bit        (w_bit)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_IDLE:     if (i_start) w_state_nxt = ST_ARM;
      ST_ARM: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (i_chain_done_in) w_state_nxt = ST_ERROR;
        else if (w_last_bit) w_state_nxt = ST_WAIT_TOK;
      end
      ST_WAIT_TOK: begin
        w_busy = 1'b1;
        if (i_chain_done_in)       w_state_nxt = ST_DONE;
        else if (r_tmo == TMO_LAST) w_state_nxt = ST_ERROR;
      end
      ST_DONE, ST_ERROR: w_state_nxt = ST_IDLE;
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bitcnt <= '0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == ST_ARM) r_bitcnt <= '0;
      else if (w_bit_vld)    r_bitcnt <= r_bitcnt + BCNT_W'(1);

      if (r_state == ST_WAIT_TOK) r_tmo <= r_tmo + TMO_W'(1);
      else                        r_tmo <= '0;

      // Status flags persist through IDLE until the next accepted start.
      if (r_state == ST_IDLE && i_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (r_state == ST_WAIT_TOK && w_state_nxt == ST_DONE) r_done <= 1'b1;
        if (r_state != ST_ERROR && w_state_nxt == ST_ERROR)   r_error <= 1'b1;
      end
    end
  end

  assign o_busy      = w_busy;
  assign o_prgm_b    = !w_busy;
  assign o_cb_prgm_b = w_bit_vld;
  assign o_cfg_data  = w_bit;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_config_chain_driver.sv
// Directed/randomized bench for config_chain_driver with a chain model that
// captures streamed bits and returns the token.
module tb_config_chain_driver;

  localparam int BPB = 26, NB = 4, WW = 8, TMO = 64;
  localparam int TOTAL = BPB * NB;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, wvalid = 1'b0, tok = 1'b0;
  logic [WW-1:0] wdata = '0;
  logic          wready, prgm_b, cb, cfg, busy, done, err;

  config_chain_driver #(
    .BITS_PER_BLOCK(BPB), .NUM_BLOCKS(NB), .WORD_W(WW), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_word_data(wdata),
    .i_word_valid(wvalid), .o_word_ready(wready), .o_prgm_b(prgm_b),
    .o_cb_prgm_b(cb), .o_cfg_data(cfg), .i_chain_done_in(tok),
    .o_busy(busy), .o_done(done), .o_error(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit exp_q[$], cap_q[$];
  int cb_cnt, first_cb, last_cb, lastbit_cyc, tok_cyc, done_cyc, err_cyc;
  int start_cyc, wacc, rdy_after_last, rdy_after_tok;
  bit pend_new, aborted, timed_out;
  logic [6:0] rst_snap;
  logic [3:0] end_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, feed the reference model.
  task automatic tick(input bit s, input bit v, input bit t);
    @(negedge clk);
    if (pend_new) begin wdata = WW'($urandom); pend_new = 1'b0; end
    start = s; wvalid = v; tok = t;
    #1;
    cyc++;
    if (wready && wvalid) begin
      for (int i = WW - 1; i >= 0; i--) exp_q.push_back(wdata[i]);
      wacc++;
      pend_new = 1'b1;
    end
    if (cb) begin
      cap_q.push_back(cfg);
      if (first_cb < 0) first_cb = cyc;
      last_cb = cyc;
      cb_cnt++;
      if (cap_q.size() == TOTAL) lastbit_cyc = cyc;
    end
    if (wready && lastbit_cyc >= 0 && cyc >= lastbit_cyc) rdy_after_last++;
    if (wready && tok_cyc >= 0 && cyc > tok_cyc) rdy_after_tok++;
    if (cyc > start_cyc) begin
      if (done && done_cyc < 0) done_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
    end
  endtask

  function automatic int stream_mism();
    int m = 0;
    for (int i = 0; i < cap_q.size(); i++)
      if (i >= exp_q.size() || cap_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  // vmode 0: valid always high, 1: random valid. tok_dly<0: never return token.
  task automatic run_pass(input int vmode, input int gap_at, input int spulse_at,
                          input int tok_dly, input int early_at, input int rst_at,
                          input int max_cyc);
    bit s = 1'b1, v, t, gap_done = 1'b0, sp_done = 1'b0, tok_done = 1'b0;
    int gap_cnt = 0;
    exp_q.delete(); cap_q.delete();
    cb_cnt = 0; first_cb = -1; last_cb = -1; lastbit_cyc = -1; tok_cyc = -1;
    done_cyc = -1; err_cyc = -1; wacc = 0; rdy_after_last = 0; rdy_after_tok = 0;
    aborted = 1'b0; pend_new = 1'b1;
    start_cyc = cyc + 1;
    for (int n = 0; n < max_cyc; n++) begin
      if (rst_at >= 0 && cap_q.size() >= rst_at) begin
        rst_n = 1'b0;
        #1;
        rst_snap = {prgm_b, cb, cfg, wready, busy, done, err};
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (gap_at >= 0 && !gap_done && cap_q.size() == gap_at) begin
        gap_cnt = 5; gap_done = 1'b1;
      end
      if (gap_cnt > 0) begin v = 1'b0; gap_cnt--; end
      if (spulse_at >= 0 && !sp_done && cap_q.size() == spulse_at) begin
        s = 1'b1; sp_done = 1'b1;
      end
      t = 1'b0;
      if (!tok_done) begin
        if (early_at >= 0) t = (cap_q.size() == early_at + 1);
        else if (tok_dly >= 0 && lastbit_cyc >= 0) t = (cyc == lastbit_cyc + tok_dly);
        if (t) begin tok_done = 1'b1; tok_cyc = cyc + 1; end
      end
      tick(s, v, t);
      s = 1'b0;
      if (done_cyc >= 0 || err_cyc >= 0) begin
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b0);
        end_snap = {prgm_b, busy, done, err};
        break;
      end
    end
    timed_out = !aborted && done_cyc < 0 && err_cyc < 0;
    wvalid = 1'b0;
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_no_hang"}, 32'(timed_out), 0);
    chk({tag, "_bits"}, cb_cnt, TOTAL);
    chk({tag, "_stream"}, stream_mism(), 0);
    chk({tag, "_captured"}, cap_q.size(), TOTAL);
    chk({tag, "_ready_after_last"}, rdy_after_last, 0);
    chk({tag, "_done_lat"}, done_cyc, tok_cyc + 1);
    chk({tag, "_end_state"}, 32'(end_snap), 32'(4'b1010));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({prgm_b, cb, cfg, wready, busy, done, err}), 32'(7'b1000000));
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    chk("idle_outputs", 32'({prgm_b, cb, wready, busy, done, err}), 32'(6'b100000));

    // Continuous stream, immediate token.
    run_pass(0, -1, -1, 0, -1, -1, 400);
    check_full("basic");
    chk("basic_first_bit", first_cb - start_cyc, 2);
    chk("basic_contiguous", last_cb - first_cb + 1, TOTAL);
    chk("basic_words", wacc, TOTAL / WW);

    // Five-cycle valid gap at the end of word 5, plus a stray start mid-shift.
    run_pass(0, 47, 60, 3, -1, -1, 400);
    check_full("gap");
    chk("gap_span", last_cb - first_cb + 1, TOTAL + 5);

    // No token returned: timeout.
    run_pass(0, -1, -1, -1, -1, -1, 400);
    chk("tmo_no_hang", 32'(timed_out), 0);
    chk("tmo_latency", err_cyc - (lastbit_cyc + 1), TMO);
    chk("tmo_no_done", done_cyc, -1);
    chk("tmo_end_state", 32'(end_snap), 32'(4'b1001));

    // Early token after bit 50.
    run_pass(0, -1, -1, 0, 50, -1, 400);
    chk("early_no_hang", 32'(timed_out), 0);
    chk("early_err_lat", err_cyc, tok_cyc + 1);
    chk("early_no_ready", rdy_after_tok, 0);
    chk("early_stream", stream_mism(), 0);
    chk("early_no_done", done_cyc, -1);
    chk("early_end_state", 32'(end_snap), 32'(4'b1001));

    // Reset at bit 30, then a clean pass.
    run_pass(0, -1, -1, 0, -1, 30, 400);
    chk("rst_aborted", 32'(aborted), 1);
    chk("rst_outputs", 32'(rst_snap), 32'(7'b1000000));
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0);
    chk("rst_idle", 32'({prgm_b, busy, done, err}), 32'(4'b1000));
    run_pass(0, -1, -1, 1, -1, -1, 400);
    check_full("after_rst");

    // Randomized valid and token delay.
    for (int r = 0; r < 3; r++) begin
      run_pass(1, -1, -1, int'($urandom_range(0, 20)), -1, -1, 1000);
      check_full($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_first_bit", r), 32'(first_cb >= start_cyc + 2), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_chain_driver.md
CONFIG_CHAIN_DRIVER -- requirements
Module: config_chain_driver

Interface
REQ-001 Parameter BITS_PER_BLOCK, default 26, is the number of configuration bits consumed by each chained block before it passes the token on.
REQ-002 Parameter NUM_BLOCKS, default 4, is the number of blocks in the daisy chain.
REQ-003 Parameter WORD_W, default 8, is the width of the input bitstream word.
REQ-004 Parameter TIMEOUT, default 64, is the maximum number of cycles to wait for the returned token.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a programming pass; sampled only in IDLE.
REQ-008 word_data  in  WORD_W  bitstream word, shifted out MSB first.
REQ-009 word_valid  in  1  word_data is valid.
REQ-010 word_ready  out  1  the driver accepts word_data this cycle; transfer occurs when valid and ready are both 1.
REQ-011 prgm_b  out  1  active-low programming-mode strobe to every block in the chain.
REQ-012 cb_prgm_b  out  1  chain enable to the first block; 1 means a bit is presented and consumed this cycle.
REQ-013 cfg_data  out  1  serial configuration bit; meaningful only while cb_prgm_b=1.
REQ-014 chain_done_in  in  1  token returned from the last block's cb_prgm_b_out.
REQ-015 busy, done, error  out  1 each  status: pass in progress; pass completed; pass failed.

Function
REQ-016 The FSM SHALL have the states IDLE, ARM, SHIFT, WAIT_TOK, DONE and ERROR.
REQ-017 In IDLE: prgm_b=1, cb_prgm_b=0, word_ready=0, busy=0; start=1 moves the FSM to ARM and clears done and error.
REQ-018 ARM SHALL last exactly one cycle with prgm_b=0 and cb_prgm_b=0, then move to SHIFT; the bit counter and the shift register SHALL be cleared.
REQ-019 In SHIFT, prgm_b=0; when the shift register holds at least one bit, cb_prgm_b=1 and cfg_data=its MSB, and the register shifts left by one bit that cycle.
REQ-020 When the shift register is empty, word_ready=1 and cb_prgm_b=0 (stall); an accepted word is loaded, and its first bit is driven on the next cycle.
REQ-021 Throughput SHALL be one bit per cycle with no bubble if word_valid is held high: word_ready SHALL also be asserted during the final-bit cycle of the current word, and a word accepted then is loaded in place.
REQ-022 The total bit count SHALL be exactly NUM_BLOCKS*BITS_PER_BLOCK; the counter width is sized for this product, not WORD_W.
REQ-023 After the last bit, word_ready SHALL stay 0; any unused trailing bits of the final word SHALL be discarded; the FSM moves to WAIT_TOK.
REQ-024 In WAIT_TOK: cb_prgm_b=0 and prgm_b=0; chain_done_in=1 moves the FSM to DONE; otherwise, after TIMEOUT cycles in WAIT_TOK, it moves to ERROR.
REQ-025 chain_done_in=1 at any time during SHIFT (an early token) SHALL move the FSM to ERROR next cycle.
REQ-026 In DONE: done=1 and prgm_b=1, held until the next accepted start; the FSM returns to IDLE the following cycle with done still held.
REQ-027 ERROR behaves the same as DONE, but with error=1 instead of done=1.
REQ-028 busy=1 in ARM, SHIFT and WAIT_TOK.
REQ-029 start SHALL be ignored outside IDLE.

Reset
REQ-030 Reset=0 SHALL immediately force: state IDLE, prgm_b=1, cb_prgm_b=0, cfg_data=0, word_ready=0, busy=0, done=0, error=0, all counters and the shift register 0.
REQ-031 Reset asserted mid-pass SHALL abort the pass; no partial token or done SHALL be reported.

Structure
REQ-032 The FSM state encoding and the BITS_PER_BLOCK default SHALL live in a shared package used by the chain blocks and this driver.
REQ-033 The serializer (shift register plus the word-load handshake) SHALL be a sub-module named cfg_serializer; the FSM and counters stay in the top level.

Verification
REQ-034 Defaults with valid always high: start, then 13 words -> cb_prgm_b high for exactly 104 consecutive cycles starting 2 cycles after start; a chain model returns the token -> done=1.
REQ-035 word_valid deasserted for 5 cycles mid-word -> cb_prgm_b=0 for those cycles, then no lost or duplicated bits; the model's captured 104 bits equal the sent stream.
REQ-036 chain_done_in held at 0 -> error=1 exactly 64 cycles after entering WAIT_TOK; prgm_b returns to 1.
REQ-037 chain_done_in pulsed after bit 50 -> error=1 on the next cycle; no further word_ready.
REQ-038 Reset=0 at bit 30 -> all outputs at their reset values in the same cycle; a new start then completes a full pass normally.
REQ-039 start pulsed during SHIFT -> ignored; the bit count is unchanged at 104.
